// File: rtl/bp_lite_to_stream_if.sv
// Message header type shared by the Lite and Stream sides, plus the two
// handshake interfaces used as ports of bp_lite_to_stream.
//   bp_lite_if   : header + full-width data, valid/ready handshake
//   bp_stream_if : header + beat data, valid/yumi handshake, lock
package bp_lite_to_stream_pkg;

  localparam int unsigned paddr_width_gp   = 40;
  localparam int unsigned payload_width_gp = 16;

  typedef enum logic [3:0] {
    e_mem_msg_rd    = 4'd0,
    e_mem_msg_wr    = 4'd1,
    e_mem_msg_uc_rd = 4'd2,
    e_mem_msg_uc_wr = 4'd3
  } mem_msg_e;

  typedef struct packed {
    logic [payload_width_gp-1:0] payload;
    logic [2:0]                  size;     // log2 of message bytes
    logic [paddr_width_gp-1:0]   addr;
    mem_msg_e                    msg_type;
  } mem_header_s;

endpackage

// Wide Lite message: one header with all of its data.
interface bp_lite_if #(parameter int unsigned data_width_p = 512);
  bp_lite_to_stream_pkg::mem_header_s header;
  logic [data_width_p-1:0]            data;
  logic                               v;
  logic                               ready;

  modport master (output header, data, v, input ready);
  modport slave  (input header, data, v, output ready);
endinterface

// Narrow Stream beat: header and one data slice; lock marks more beats to come.
interface bp_stream_if #(parameter int unsigned data_width_p = 64);
  bp_lite_to_stream_pkg::mem_header_s header;
  logic [data_width_p-1:0]            data;
  logic                               v;
  logic                               yumi;
  logic                               lock;

  modport master (output header, data, v, lock, input yumi);
  modport slave  (input header, data, v, lock, output yumi);
endinterface

// File: rtl/bp_lite_to_stream.sv
// Serializes one Lite message (header + wide data) into Stream beats.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset
//   lite_i         : Lite input (header, data, v in; ready out)
//   stream_o       : Stream output (header, data, v, lock out; yumi in)
module bp_lite_to_stream
  import bp_lite_to_stream_pkg::*;
#(
  parameter int unsigned in_data_width_p  = 512,
  parameter int unsigned out_data_width_p = 64,
  parameter bit          master_p         = 1'b0
) (
  input  logic         clk_i,
  input  logic         reset_i,
  bp_lite_if.slave     lite_i,
  bp_stream_if.master  stream_o
);

  localparam int unsigned stream_words_lp = in_data_width_p / out_data_width_p;
  localparam int unsigned out_bytes_lp    = out_data_width_p / 8;
  localparam int unsigned cnt_w_lp        = (stream_words_lp > 1) ? $clog2(stream_words_lp) : 1;
  localparam int unsigned addr_w_lp       = paddr_width_gp;
  localparam bit          widths_ok_lp    = ((in_data_width_p % out_data_width_p) == 0);

  typedef enum logic {e_ready, e_stream} state_e;

  state_e                     state_q, state_d;
  mem_header_s                header_q, header_d;
  logic [in_data_width_p-1:0] data_q, data_d;
  logic [cnt_w_lp-1:0]        cnt_q, cnt_d;
  logic                       ready_q, ready_d;
  logic                       v_q, v_d;
  logic                       lock_q, lock_d;
  logic                       last_c;

  // Index of the final beat for a given header.
  function automatic logic [cnt_w_lp-1:0] last_beat(input mem_header_s h);
    logic        is_wr;
    logic        has_data;
    int unsigned beats;
    is_wr    = (h.msg_type == e_mem_msg_wr) || (h.msg_type == e_mem_msg_uc_wr);
    has_data = master_p ? is_wr : !is_wr;
    beats    = 1;
    if (has_data) beats = (32'(1) << h.size) / out_bytes_lp;
    if (beats == 0) beats = 1;
    // Oversized messages are illegal; clamp to keep the counter in range.
    if (beats > stream_words_lp) beats = stream_words_lp;
    return cnt_w_lp'(beats - 1);
  endfunction

  assign last_c = (cnt_q == last_beat(header_q));

  // Next-state: accept one message, then walk header address and data per beat.
  always_comb begin
    state_d  = state_q;
    header_d = header_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    case (state_q)
      e_ready: begin
        if (lite_i.v && ready_q) begin
          state_d  = e_stream;
          header_d = lite_i.header;
          data_d   = lite_i.data;
          cnt_d    = '0;
        end
      end
      e_stream: begin
        if (stream_o.yumi) begin
          if (last_c) begin
            state_d = e_ready;
          end else begin
            cnt_d         = cnt_q + cnt_w_lp'(1);
            header_d.addr = header_q.addr + addr_w_lp'(out_bytes_lp);
            data_d        = data_q >> out_data_width_p;
          end
        end
      end
      default: state_d = e_ready;
    endcase
    ready_d = (state_d == e_ready);
    v_d     = (state_d == e_stream);
    lock_d  = v_d && (cnt_d != last_beat(header_d));
  end

  // State and registered handshake outputs; ready/valid held low under reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= e_ready;
      header_q <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      v_q      <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      header_q <= header_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      v_q      <= v_d;
      lock_q   <= lock_d;
    end
  end

  assign lite_i.ready    = ready_q;
  assign stream_o.v      = v_q;
  assign stream_o.lock   = lock_q;
  assign stream_o.header = header_q;
  assign stream_o.data   = data_q[out_data_width_p-1:0];

  // Simulation checks on configuration and handshake usage.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      a_width: assert (widths_ok_lp);
      a_yumi:  assert (!stream_o.yumi || v_q);
      if (lite_i.v && ready_q) begin
        a_size: assert ((32'(1) << lite_i.header.size) <= (in_data_width_p / 8));
      end
    end
  end

endmodule

// File: tb/tb_bp_lite_to_stream.sv
module tb_bp_lite_to_stream;
  import bp_lite_to_stream_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bp_lite_if   #(.data_width_p(512)) lite_m ();
  bp_lite_if   #(.data_width_p(512)) lite_s ();
  bp_stream_if #(.data_width_p(64))  str_m ();
  bp_stream_if #(.data_width_p(64))  str_s ();

  // Shared stimulus; sel picks the command-path (1) or response-path (0) DUT.
  mem_header_s  tb_hdr;
  logic [511:0] tb_data;
  logic         tb_v;
  logic         tb_yumi;
  logic         sel;

  assign lite_m.header = tb_hdr;
  assign lite_s.header = tb_hdr;
  assign lite_m.data   = tb_data;
  assign lite_s.data   = tb_data;
  assign lite_m.v      = tb_v & sel;
  assign lite_s.v      = tb_v & ~sel;
  // Consumer only yumis a presented beat.
  assign str_m.yumi    = tb_yumi & sel & str_m.v;
  assign str_s.yumi    = tb_yumi & ~sel & str_s.v;

  bp_lite_to_stream #(.in_data_width_p(512), .out_data_width_p(64), .master_p(1'b1)) dut_m (
    .clk_i(clk), .reset_i(reset), .lite_i(lite_m), .stream_o(str_m));
  bp_lite_to_stream #(.in_data_width_p(512), .out_data_width_p(64), .master_p(1'b0)) dut_s (
    .clk_i(clk), .reset_i(reset), .lite_i(lite_s), .stream_o(str_s));

  logic        o_ready, o_v, o_lock;
  mem_header_s o_hdr;
  logic [63:0] o_data;
  assign o_ready = sel ? lite_m.ready : lite_s.ready;
  assign o_v     = sel ? str_m.v      : str_s.v;
  assign o_lock  = sel ? str_m.lock   : str_s.lock;
  assign o_hdr   = sel ? str_m.header : str_s.header;
  assign o_data  = sel ? str_m.data   : str_s.data;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [511:0] make_data(input int unsigned seed);
    logic [511:0] d;
    for (int i = 0; i < 64; i++) d[i*8 +: 8] = 8'(i + seed);
    return d;
  endfunction

  function automatic mem_header_s make_hdr(input mem_msg_e t, input logic [2:0] sz,
                                           input logic [39:0] a, input logic [15:0] pl);
    mem_header_s h;
    h          = '0;
    h.msg_type = t;
    h.size     = sz;
    h.addr     = a;
    h.payload  = pl;
    return h;
  endfunction

  // Called at a negedge with the converter idle; returns with beat 0 presented.
  task automatic send(input mem_header_s h, input logic [511:0] d);
    check("ready_before_accept", 64'(o_ready), 64'd1);
    tb_hdr  = h;
    tb_data = d;
    tb_v    = 1'b1;
    @(negedge clk);
    tb_v    = 1'b0;
    tb_hdr  = '0;
    tb_data = '1;
  endtask

  // Checks one presented beat against the model.
  task automatic check_beat(input mem_header_s h, input logic [511:0] d,
                            input int unsigned k, input int unsigned beats);
    mem_header_s exp;
    exp      = h;
    exp.addr = h.addr + 40'(8 * k);
    check("beat_v",     64'(o_v),     64'd1);
    check("beat_ready", 64'(o_ready), 64'd0);
    check("beat_hdr",   64'(o_hdr),   64'(exp));
    check("beat_data",  o_data,       d[k*64 +: 64]);
    check("beat_lock",  64'(o_lock),  64'(k != beats - 1));
  endtask

  // With yumi high, checks beats first..beats-1 then the return to idle.
  task automatic run_beats(input mem_header_s h, input logic [511:0] d,
                           input int unsigned first, input int unsigned beats);
    for (int unsigned k = first; k < beats; k++) begin
      check_beat(h, d, k, beats);
      @(negedge clk);
    end
    check("end_v",     64'(o_v),     64'd0);
    check("end_ready", 64'(o_ready), 64'd1);
  endtask

  typedef struct {
    logic        sel;
    mem_msg_e    t;
    logic [2:0]  size;
    logic [39:0] addr;
    int unsigned beats;
  } vec_t;

  vec_t        vecs[8];
  mem_header_s h;
  logic [511:0] d;

  initial begin
    vecs[0] = '{1'b1, e_mem_msg_wr,    3'd6, 40'h00_8000_0040, 8}; // full-block write
    vecs[1] = '{1'b1, e_mem_msg_rd,    3'd6, 40'h00_8000_1000, 1}; // read command
    vecs[2] = '{1'b0, e_mem_msg_rd,    3'd5, 40'h00_0000_2000, 4}; // 32 B read response
    vecs[3] = '{1'b0, e_mem_msg_wr,    3'd6, 40'h00_0000_3000, 1}; // write response
    vecs[4] = '{1'b1, e_mem_msg_uc_wr, 3'd2, 40'h00_0000_4004, 1}; // sub-beat
    vecs[5] = '{1'b0, e_mem_msg_uc_rd, 3'd3, 40'h00_0000_5000, 1}; // exactly one beat
    vecs[6] = '{1'b1, e_mem_msg_uc_wr, 3'd4, 40'hFF_FFFF_FFF8, 2}; // address wraps
    vecs[7] = '{1'b0, e_mem_msg_uc_rd, 3'd6, 40'h00_0000_7000, 8}; // full-block response

    reset   = 1'b1;
    tb_v    = 1'b0;
    tb_yumi = 1'b1;
    tb_hdr  = '0;
    tb_data = '0;
    sel     = 1'b1;

    // Reset held 3 cycles: no ready, no valid on either instance.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_ready_m", 64'(lite_m.ready), 64'd0);
      check("rst_ready_s", 64'(lite_s.ready), 64'd0);
      check("rst_v_m",     64'(str_m.v),      64'd0);
      check("rst_v_s",     64'(str_s.v),      64'd0);
      check("rst_lock_m",  64'(str_m.lock),   64'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready_m", 64'(lite_m.ready), 64'd1);
    check("post_rst_ready_s", 64'(lite_s.ready), 64'd1);
    check("post_rst_v_m",     64'(str_m.v),      64'd0);

    // Table-driven messages, yumi held high.
    for (int i = 0; i < 8; i++) begin
      sel = vecs[i].sel;
      h   = make_hdr(vecs[i].t, vecs[i].size, vecs[i].addr, 16'(i * 17 + 3));
      d   = make_data(32'(i * 64));
      send(h, d);
      run_beats(h, d, 0, vecs[i].beats);
    end

    // Backpressure: stall 5 cycles on beat 3 of a 64 B write.
    sel = 1'b1;
    h   = make_hdr(e_mem_msg_wr, 3'd6, 40'h00_8000_0000, 16'h00AB);
    d   = make_data(0);
    send(h, d);
    for (int unsigned k = 0; k < 3; k++) begin
      check_beat(h, d, k, 8);
      @(negedge clk);
    end
    check_beat(h, d, 3, 8);
    tb_yumi = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_v",     64'(o_v),      64'd1);
      check("stall_ready", 64'(o_ready),  64'd0);
      check("stall_addr",  64'(o_hdr.addr), 64'h00_8000_0018);
      check("stall_data",  o_data,        64'h1F1E1D1C1B1A1918);
      check("stall_lock",  64'(o_lock),   64'd1);
    end
    tb_yumi = 1'b1;
    check_beat(h, d, 3, 8);
    @(negedge clk);
    run_beats(h, d, 4, 8);

    // Reset asserted while beat 2 of a 64 B stream is presented.
    h = make_hdr(e_mem_msg_wr, 3'd6, 40'h00_9000_0000, 16'h0055);
    d = make_data(5);
    send(h, d);
    for (int unsigned k = 0; k < 2; k++) begin
      check_beat(h, d, k, 8);
      @(negedge clk);
    end
    check_beat(h, d, 2, 8);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_v",     64'(o_v),     64'd0);
    check("midrst_ready", 64'(o_ready), 64'd0);
    check("midrst_lock",  64'(o_lock),  64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("after_rst_ready", 64'(o_ready), 64'd1);
    check("after_rst_v",     64'(o_v),     64'd0);

    // Converter still works after the dropped message.
    h = make_hdr(e_mem_msg_rd, 3'd6, 40'h00_A000_0000, 16'h0077);
    d = make_data(9);
    send(h, d);
    run_beats(h, d, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
